// File: rtl/alu_serial_frame_rx_pkg.sv
// Shared types, CRC polynomial and the serial CRC-4 step for the ALU command receiver.
package alu_rx_pkg;

  typedef enum logic {
    PKT_DATA = 1'b0,
    PKT_CTL  = 1'b1
  } packet_type_t;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } operation_t;

  typedef struct packed {
    logic err_data;
    logic err_crc;
    logic err_op;
  } err_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TYPE,
    ST_PAYLOAD,
    ST_STOP
  } pkt_state_t;

  localparam logic [3:0] CRC_POLY = 4'b0011;

  // One serial step of x^4+x+1, data bit entering at the top.
  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic d);
    logic fb;
    fb = crc[3] ^ d;
    return {crc[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'b0000);
  endfunction

endpackage

// File: rtl/alu_serial_frame_rx_if.sv
// Decoded-command bus between the frame receiver (master) and the ALU datapath (slave).
interface alu_serial_frame_rx_if #(
  parameter int N_BYTES = 4
);
  import alu_rx_pkg::*;

  localparam int W = 8 * N_BYTES;

  // Valid/ready: a transfer happens at a posedge where out_valid && out_ready;
  // while out_valid && !out_ready every out_* field holds stable.
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic [2:0]   out_op;
  err_t         out_err;

  modport master (
    output out_valid, out_a, out_b, out_op, out_err,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_a, out_b, out_op, out_err,
    output out_ready
  );

endinterface

// File: rtl/alu_serial_frame_rx_pkt.sv
// Bit-level packet receiver: start, type, 8 payload bits MSB first, stop.
module serial_packet_rx
  import alu_rx_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sin_i,
  output logic         pkt_valid_o,
  output packet_type_t pkt_type_o,
  output logic [7:0]   pkt_byte_o,
  output logic         framing_err_o,
  output pkt_state_t   state_o
);

  pkt_state_t   state_q, state_d;
  packet_type_t type_q, type_d;
  logic [7:0]   shift_q, shift_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      type_q    <= PKT_DATA;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!sin_i) state_d = ST_TYPE;
      end
      ST_TYPE: begin
        type_d    = packet_type_t'(sin_i);
        bit_cnt_d = 3'd7;
        state_d   = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        shift_d   = {shift_q[6:0], sin_i};
        bit_cnt_d = bit_cnt_q - 3'd1;
        if (bit_cnt_q == 3'd0) state_d = ST_STOP;
      end
      ST_STOP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The packet is delivered (or rejected) in the cycle its stop bit is on the line.
  always_comb begin
    pkt_valid_o   = (state_q == ST_STOP) && sin_i;
    framing_err_o = (state_q == ST_STOP) && !sin_i;
    pkt_type_o    = type_q;
    pkt_byte_o    = shift_q;
    state_o       = state_q;
  end

endmodule

// File: rtl/alu_serial_frame_rx.sv
// Serial ALU command frame receiver: assembles B, A and CTL, checks length/CRC/opcode,
// and holds the decoded command in a valid/ready output register.
module alu_serial_frame_rx
  import alu_rx_pkg::*;
#(
  parameter int         N_BYTES       = 4,
  parameter logic [7:0] OP_LEGAL_MASK = 8'b0011_0011
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sin,
  alu_serial_frame_rx_if.master        out_if,
  output logic                         overrun,
  output logic                         framing_err,
  output pkt_state_t                   dbg_pkt_state
);

  localparam int W   = 8 * N_BYTES;
  localparam int NB2 = 2 * N_BYTES;
  localparam int CW  = $clog2(NB2 + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(NB2);
  localparam logic [CW-1:0] CNT_SAT  = CW'(NB2 + 1);

  logic         pkt_valid;
  packet_type_t pkt_type;
  logic [7:0]   pkt_byte;
  logic         framing_pulse;

  serial_packet_rx u_pkt (
    .clk           (clk),
    .rst_n         (rst_n),
    .sin_i         (sin),
    .pkt_valid_o   (pkt_valid),
    .pkt_type_o    (pkt_type),
    .pkt_byte_o    (pkt_byte),
    .framing_err_o (framing_pulse),
    .state_o       (dbg_pkt_state)
  );

  logic [CW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]     crc_q, crc_d;
  logic [2*W-1:0] data_q, data_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]     op_q, op_d;
  err_t           err_q, err_d;
  logic           overrun_q, overrun_d;
  logic           framing_err_q, framing_err_d;

  logic [2:0] ctl_op;
  logic [3:0] ctl_crc;
  logic [3:0] crc_final;
  logic       frame_done;
  err_t       frame_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt_q    <= '0;
      crc_q         <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      err_q         <= '0;
      overrun_q     <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      byte_cnt_q    <= byte_cnt_d;
      crc_q         <= crc_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      err_q         <= err_d;
      overrun_q     <= overrun_d;
      framing_err_q <= framing_err_d;
    end
  end

  // Frame assembly and classification; the CTL byte feeds 1'b1 then op into the CRC.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    data_d     = data_q;
    ctl_op     = pkt_byte[6:4];
    ctl_crc    = pkt_byte[3:0];
    crc_final  = crc4_step(crc_q, 1'b1);
    for (int i = 2; i >= 0; i--) crc_final = crc4_step(crc_final, ctl_op[i]);

    frame_err = '0;
    if (byte_cnt_q != CNT_FULL)              frame_err.err_data = 1'b1;
    else if (crc_final != ctl_crc)           frame_err.err_crc  = 1'b1;
    else if (!OP_LEGAL_MASK[ctl_op])         frame_err.err_op   = 1'b1;

    frame_done = pkt_valid && (pkt_type == PKT_CTL);

    if (framing_pulse || frame_done) begin
      byte_cnt_d = '0;
      crc_d      = '0;
      data_d     = '0;
    end else if (pkt_valid) begin
      if (byte_cnt_q < CNT_FULL) begin
        data_d = {data_q[2*W-9:0], pkt_byte};
        for (int i = 7; i >= 0; i--) crc_d = crc4_step(crc_d, pkt_byte[i]);
      end
      if (byte_cnt_q != CNT_SAT) byte_cnt_d = byte_cnt_q + CW'(1);
    end
  end

  // Output register: a completing frame loads only if the slot is free or draining.
  always_comb begin
    valid_d       = valid_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    err_d         = err_q;
    overrun_d     = overrun_q;
    framing_err_d = framing_pulse;

    if (valid_q && out_if.out_ready) valid_d = 1'b0;

    if (frame_done) begin
      if (!valid_q || out_if.out_ready) begin
        valid_d = 1'b1;
        a_d     = data_q[W-1:0];
        b_d     = data_q[2*W-1:W];
        op_d    = ctl_op;
        err_d   = frame_err;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_a     = a_q;
  assign out_if.out_b     = b_q;
  assign out_if.out_op    = op_q;
  assign out_if.out_err   = err_q;
  assign overrun          = overrun_q;
  assign framing_err      = framing_err_q;

endmodule

// File: tb/tb_alu_serial_frame_rx.sv
// Bench for alu_serial_frame_rx: directed protocol cases plus randomized frames
// scored against a frame-level model of the command protocol.
module tb_alu_serial_frame_rx;
  import alu_rx_pkg::*;

  localparam int NB = 4;
  localparam int W  = 8 * NB;
  localparam int EW = 1 + 2 * W + 6;
  localparam logic [7:0] LEGAL = 8'b0011_0011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sin = 1'b1;
  logic sin1 = 1'b1;
  logic overrun, framing_err, overrun1, framing_err1;
  pkt_state_t dbg0, dbg1;
  logic ready_fixed = 1'b0;
  logic rand_ready_en = 1'b0;
  logic chk_en = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];

  alu_serial_frame_rx_if #(.N_BYTES(NB)) bus ();
  alu_serial_frame_rx_if #(.N_BYTES(1))  bus1 ();

  alu_serial_frame_rx #(.N_BYTES(NB), .OP_LEGAL_MASK(LEGAL)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .out_if(bus),
    .overrun(overrun), .framing_err(framing_err), .dbg_pkt_state(dbg0)
  );

  alu_serial_frame_rx #(.N_BYTES(1), .OP_LEGAL_MASK(LEGAL)) dut1 (
    .clk(clk), .rst_n(rst_n), .sin(sin1), .out_if(bus1),
    .overrun(overrun1), .framing_err(framing_err1), .dbg_pkt_state(dbg1)
  );

  assign bus1.out_ready = 1'b1;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial bus.out_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_ready_en ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] model_crc(input logic [63:0] b, input logic [63:0] a,
                                           input int nb, input logic [2:0] op);
    logic [3:0] c;
    logic [3:0] bits;
    logic d;
    c = 4'h0;
    bits = {1'b1, op};
    for (int i = 0; i < 16 * nb + 4; i++) begin
      if (i < 8 * nb)       d = b[8 * nb - 1 - i];
      else if (i < 16 * nb) d = a[16 * nb - 1 - i];
      else                  d = bits[3 - (i - 16 * nb)];
      c = {c[2:0], 1'b0} ^ ((c[3] ^ d) ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  function automatic logic [2:0] model_err(input int n_data, input int nb, input logic [63:0] b,
                                           input logic [63:0] a, input logic [2:0] op,
                                           input logic [3:0] crc_in);
    if (n_data != 2 * nb) return 3'b100;
    if (model_crc(b, a, nb, op) != crc_in) return 3'b010;
    if (!LEGAL[op]) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [63:0] b, input logic [63:0] a,
                                            input int nb, input int i);
    if (i < nb)     return 8'(b >> (8 * (nb - 1 - i)));
    if (i < 2 * nb) return 8'(a >> (8 * (2 * nb - 1 - i)));
    return 8'($urandom_range(0, 255));
  endfunction

  // ---------------- drivers ----------------
  task automatic send_bit(input int port, input logic b);
    if (port == 0) sin = b;
    else sin1 = b;
    tick();
  endtask

  task automatic send_packet(input int port, input logic typ, input logic [7:0] data, input logic stop);
    int gap;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) send_bit(port, 1'b1);
    send_bit(port, 1'b0);
    send_bit(port, typ);
    for (int i = 7; i >= 0; i--) send_bit(port, data[i]);
    send_bit(port, stop);
    if (port == 0) sin = 1'b1;
    else sin1 = 1'b1;
  endtask

  task automatic send_frame(input int port, input int nb, input int n_data, input logic [63:0] b,
                            input logic [63:0] a, input logic [2:0] op, input logic [3:0] crc_in);
    for (int i = 0; i < n_data; i++) send_packet(port, 1'b0, frame_byte(b, a, nb, i), 1'b1);
    send_packet(port, 1'b1, {1'b0, op, crc_in}, 1'b1);
  endtask

  task automatic model_frame(input int n_data, input logic [63:0] b, input logic [63:0] a,
                             input logic [2:0] op, input logic [3:0] crc_in, input logic expect_it);
    logic [2:0] e;
    e = model_err(n_data, NB, b, a, op, crc_in);
    if (expect_it) exp_q.push_back({(n_data == 2 * NB), a[W-1:0], b[W-1:0], op, e});
    send_frame(0, NB, n_data, b, a, op, crc_in);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d frames pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_ab"}, {bus.out_a, bus.out_b}, 0);
    check({tag, "_op_err"}, {bus.out_op, bus.out_err}, 0);
    check({tag, "_flags"}, {overrun, framing_err, overrun1, framing_err1, bus1.out_valid}, 0);
    check({tag, "_state"}, {dbg0, dbg1}, {ST_IDLE, ST_IDLE});
  endtask

  // ---------------- scoreboard / compare ----------------
  logic held = 1'b0;
  logic [2*W+5:0] snap;

  always @(negedge clk) begin
    logic [2*W+5:0] cur;
    logic [EW-1:0] e;
    if (!rst_n || !chk_en) begin
      held = 1'b0;
    end else begin
      cur = {bus.out_a, bus.out_b, bus.out_op, bus.out_err};
      if (held) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_fields", cur, snap);
      end
      if (bus.out_valid) begin
        check("err_onehot0", $onehot0(bus.out_err), 1);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: out_valid=1 with no frame expected");
        end else if (bus.out_ready) begin
          e = exp_q.pop_front();
          if (e[EW-1]) begin
            check("sb_a", bus.out_a, e[6+W +: W]);
            check("sb_b", bus.out_b, e[6 +: W]);
          end
          check("sb_op", bus.out_op, e[5:3]);
          check("sb_err", bus.out_err, e[2:0]);
        end
      end
      held = bus.out_valid && !bus.out_ready;
      snap = cur;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] b, a;
    logic [2:0] op;
    logic [3:0] crc;
    int n_data;

    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    ready_fixed = 1'b1;
    chk_en = 1'b1;
    tick();
    tick();

    // Correct frame with hand-computed CRC, latency and one-cycle pulse.
    exp_q.push_back({1'b1, 32'h1, 32'h2, 3'b100, 3'b000});
    send_frame(0, NB, 8, 64'h2, 64'h1, 3'b100, 4'hC);
    @(negedge clk);
    check("t1_latency_valid", bus.out_valid, 1);
    check("t1_fields", {bus.out_a, bus.out_b, bus.out_op, bus.out_err}, {32'h1, 32'h2, 3'b100, 3'b000});
    @(negedge clk);
    check("t1_pulse_drop", bus.out_valid, 0);

    // Bad CRC.
    model_frame(8, 64'h2, 64'h1, 3'b100, 4'hD, 1'b1);
    @(negedge clk);
    check("t2_err_crc", {bus.out_valid, bus.out_err}, {1'b1, 3'b010});
    wait_drain(20);

    // Short frame then a clean one.
    model_frame(3, 64'h2, 64'h1, 3'b100, 4'hC, 1'b1);
    @(negedge clk);
    check("t3_err_data", {bus.out_valid, bus.out_err}, {1'b1, 3'b100});
    wait_drain(20);
    b = {32'h0, $urandom};
    a = {32'h0, $urandom};
    model_frame(8, b, a, 3'b101, model_crc(b, a, NB, 3'b101), 1'b1);
    wait_drain(20);

    // Illegal opcode with a legal CRC.
    b = {32'h0, $urandom};
    a = {32'h0, $urandom};
    model_frame(8, b, a, 3'b010, model_crc(b, a, NB, 3'b010), 1'b1);
    @(negedge clk);
    check("t4_err_op", {bus.out_valid, bus.out_op, bus.out_err}, {1'b1, 3'b010, 3'b001});
    wait_drain(20);

    // Back-pressure: second frame is dropped and overrun sticks.
    ready_fixed = 1'b0;
    tick();
    tick();
    model_frame(8, 64'h2, 64'h1, 3'b100, 4'hC, 1'b1);
    model_frame(8, 64'h5, 64'h7, 3'b000, model_crc(64'h5, 64'h7, NB, 3'b000), 1'b0);
    @(negedge clk);
    check("t5_overrun", overrun, 1);
    check("t5_held", {bus.out_valid, bus.out_a, bus.out_b}, {1'b1, 32'h1, 32'h2});
    ready_fixed = 1'b1;
    wait_drain(20);
    repeat (20) tick();
    @(negedge clk);
    check("t5_single_transfer", bus.out_valid, 0);
    check("t5_overrun_sticky", overrun, 1);

    // Framing error on the fifth byte's stop bit abandons the frame.
    for (int i = 0; i < 4; i++) send_packet(0, 1'b0, 8'($urandom_range(0, 255)), 1'b1);
    send_packet(0, 1'b0, 8'h5A, 1'b0);
    @(negedge clk);
    check("t6_framing_pulse", framing_err, 1);
    @(negedge clk);
    check("t6_framing_one_cycle", framing_err, 0);
    repeat (30) tick();
    b = {32'h0, $urandom};
    a = {32'h0, $urandom};
    model_frame(8, b, a, 3'b001, model_crc(b, a, NB, 3'b001), 1'b1);
    wait_drain(20);

    // Reset in the middle of the third byte.
    send_packet(0, 1'b0, 8'h11, 1'b1);
    send_packet(0, 1'b0, 8'h22, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("midreset");
    rst_n = 1'b1;
    tick();
    b = {32'h0, $urandom};
    a = {32'h0, $urandom};
    model_frame(8, b, a, 3'b100, model_crc(b, a, NB, 3'b100), 1'b1);
    wait_drain(20);

    // Single-byte operands with hand-computed CRC 6.
    send_frame(1, 1, 2, 64'h2, 64'h1, 3'b100, 4'h6);
    @(negedge clk);
    check("n1_good", {bus1.out_valid, bus1.out_a, bus1.out_b, bus1.out_op, bus1.out_err},
          {1'b1, 8'h1, 8'h2, 3'b100, 3'b000});
    @(negedge clk);
    check("n1_pulse_drop", bus1.out_valid, 0);
    send_frame(1, 1, 2, 64'h2, 64'h1, 3'b100, 4'h7);
    @(negedge clk);
    check("n1_bad_crc", {bus1.out_valid, bus1.out_err}, {1'b1, 3'b010});

    // Randomized frames with random consumer stalls.
    rand_ready_en = 1'b1;
    for (int f = 0; f < 30; f++) begin
      b = {32'h0, $urandom};
      a = {32'h0, $urandom};
      op = 3'($urandom_range(0, 7));
      n_data = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * NB + 2) : 2 * NB;
      crc = model_crc(b, a, NB, op);
      if ($urandom_range(0, 3) == 0) crc = crc ^ 4'($urandom_range(1, 15));
      model_frame(n_data, b, a, op, crc, 1'b1);
      wait_drain(300);
    end
    rand_ready_en = 1'b0;
    repeat (10) tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
